// File: rtl/clock_pulse_gen_pkg.sv
// clock_pulse_gen_pkg: shared mode and state types for the pulse generator
package clock_pulse_gen_pkg;
  typedef enum logic [1:0] {MODE_CONT, MODE_ONESHOT, MODE_BURST, MODE_RSVD} pulse_mode_t;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/clock_pulse_gen_if.sv
// clock_pulse_gen_if: control/config inputs and pulse/status outputs of clock_pulse_gen
//   master drives i_enable, i_start, i_mode, i_period, i_high, i_burst_cnt
//   slave (the generator) drives o_pulse, o_busy, o_period_tick, o_done, o_cfg_err
interface clock_pulse_gen_if
  import clock_pulse_gen_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
);
  logic                   i_enable;
  logic                   i_start;
  pulse_mode_t            i_mode;
  logic [CNT_WIDTH-1:0]   i_period;
  logic [CNT_WIDTH-1:0]   i_high;
  logic [BURST_WIDTH-1:0] i_burst_cnt;
  logic                   o_pulse;
  logic                   o_busy;
  logic                   o_period_tick;
  logic                   o_done;
  logic                   o_cfg_err;
  modport master (
    output i_enable, i_start, i_mode, i_period, i_high, i_burst_cnt,
    input  o_pulse, o_busy, o_period_tick, o_done, o_cfg_err
  );
  modport slave (
    input  i_enable, i_start, i_mode, i_period, i_high, i_burst_cnt,
    output o_pulse, o_busy, o_period_tick, o_done, o_cfg_err
  );
endinterface

// File: rtl/clock_pulse_gen_phase_counter.sv
// pulse_phase_counter: wrapping counter 0..term_i with clear, enable and terminal strobe
//   clr_i forces zero, en_i advances, term_o is high while cnt_o == term_i,
//   cnt_d_o exposes the next count so callers can register outputs against it
module pulse_phase_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] term_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [CNT_WIDTH-1:0] cnt_d_o,
  output logic                 term_o
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  assign term_o  = cnt_q == term_i;
  assign cnt_d   = clr_i ? '0 : !en_i ? cnt_q : term_o ? '0 : cnt_q + 1'b1;
  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/clock_pulse_gen.sv
// clock_pulse_gen: programmable periodic pulse generator (continuous, one-shot, burst)
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : enable/start/config in, registered pulse/busy/tick/done/cfg_err out
module clock_pulse_gen
  import clock_pulse_gen_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
) (
  input logic               i_clk,
  input logic               i_rst_n,
  clock_pulse_gen_if.slave  bus
);
  state_t                 state_q, state_d;
  pulse_mode_t            mode_q;
  logic [CNT_WIDTH-1:0]   period_q, high_q, cnt, cnt_d, term_val;
  logic [BURST_WIDTH-1:0] burst_q, periods_q, periods_d;
  logic pulse_q, pulse_d, busy_q, tick_q, tick_d, done_q, done_d, err_q, err_d;
  logic accept, cfg_ok, last, clr, term;
  assign accept   = state_q == ST_IDLE && bus.i_enable && bus.i_start;
  assign cfg_ok   = bus.i_period != '0 && bus.i_high != '0 && bus.i_high <= bus.i_period &&
                    bus.i_mode != MODE_RSVD && !(bus.i_mode == MODE_BURST && bus.i_burst_cnt == '0);
  assign term_val = period_q - 1'b1;
  // periods_q counts periods already completed, so the current one is final when it equals count-1
  assign last     = mode_q == MODE_ONESHOT || (mode_q == MODE_BURST && periods_q == burst_q - 1'b1);
  pulse_phase_counter #(.CNT_WIDTH(CNT_WIDTH)) u_phase (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr_i   (clr),
    .en_i    (1'b1),
    .term_i  (term_val),
    .cnt_o   (cnt),
    .cnt_d_o (cnt_d),
    .term_o  (term)
  );
  // Outputs are registered from the phase the counter will hold next cycle
  always_comb begin
    state_d   = state_q;
    periods_d = periods_q;
    clr       = 1'b1;
    pulse_d   = 1'b0;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept && cfg_ok) begin
        state_d   = ST_RUN;
        periods_d = '0;
        pulse_d   = 1'b1;
        tick_d    = bus.i_period == CNT_WIDTH'(1);
      end else err_d = accept;
    end else if (!bus.i_enable) state_d = ST_IDLE;
    else if (term && last) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end else begin
      clr       = 1'b0;
      pulse_d   = cnt_d < high_q;
      tick_d    = cnt_d == term_val;
      periods_d = term ? periods_q + 1'b1 : periods_q;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_CONT;
      period_q  <= '0;
      high_q    <= '0;
      burst_q   <= '0;
      periods_q <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      periods_q <= periods_d;
      pulse_q   <= pulse_d;
      busy_q    <= state_d == ST_RUN;
      tick_q    <= tick_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (accept) begin
        mode_q   <= bus.i_mode;
        period_q <= bus.i_period;
        high_q   <= bus.i_high;
        burst_q  <= bus.i_burst_cnt;
      end
    end
  assign bus.o_pulse       = pulse_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_period_tick = tick_q;
  assign bus.o_done        = done_q;
  assign bus.o_cfg_err     = err_q;
endmodule

// File: tb/tb_clock_pulse_gen.sv
// tb_clock_pulse_gen: scoreboard bench for clock_pulse_gen with a run-length reference model
module tb_clock_pulse_gen;
  import clock_pulse_gen_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  clock_pulse_gen_if bus ();
  clock_pulse_gen dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [4:0] exp_q[$];
  bit m_run = 0;
  int m_ts, m_p, m_h, m_len;
  function automatic logic [4:0] outs();
    return {bus.o_pulse, bus.o_busy, bus.o_period_tick, bus.o_done, bus.o_cfg_err};
  endfunction
  // Monitor: one expected output vector per driven cycle, compared just after the edge
  initial forever begin
    logic [4:0] e, a;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = outs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t {pulse,busy,tick,done,err} got=%b exp=%b", $time, a, e);
      end
    end
  end
  task automatic chk_zero(input string nm);
    checks++;
    if (outs() !== 5'b0) begin
      failures++;
      $display("FAIL %s got=%b exp=00000", nm, outs());
    end
  endtask
  // Drive one cycle and predict the outputs of the following cycle.
  // A run started at cycle ts lasts len cycles (0 = forever); cycle ts+k shows phase k-1.
  task automatic step(input bit en, input bit st, input int md, input int p, input int h, input int n);
    logic [4:0] e;
    int k;
    @(negedge clk);
    bus.i_enable    = en;
    bus.i_start     = st;
    bus.i_mode      = pulse_mode_t'(md[1:0]);
    bus.i_period    = 16'(p);
    bus.i_high      = 16'(h);
    bus.i_burst_cnt = 8'(n);
    e = '0;
    if (m_run) begin
      k = cyc + 1 - m_ts;
      if (!en) m_run = 0;
      else if (m_len != 0 && k > m_len) begin
        e[1] = 1'b1;
        m_run = 0;
      end else e = {((k - 1) % m_p) < m_h, 1'b1, (k % m_p) == 0, 2'b00};
    end else if (en && st) begin
      if (p != 0 && h != 0 && h <= p && md != 3 && !(md == 2 && n == 0)) begin
        m_run = 1;
        m_ts  = cyc;
        m_p   = p;
        m_h   = h;
        m_len = md == 0 ? 0 : md == 1 ? p : n * p;
        e = {1'b1, 1'b1, p == 1, 2'b00};
      end else e[0] = 1'b1;
    end
    exp_q.push_back(e);
    cyc++;
  endtask
  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) step(1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.i_enable = 0; bus.i_start = 0; bus.i_mode = MODE_CONT;
    bus.i_period = '0; bus.i_high = '0; bus.i_burst_cnt = '0;
    #2 chk_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // mid-run asynchronous reset
    step(1, 1, 0, 8, 3, 0);
    idle(4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset_midrun");
    exp_q.delete();
    m_run = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 1, 3, 1, 0);
    idle(5);
    // continuous P=5 H=2, enable dropped at cycle 12
    step(1, 1, 0, 5, 2, 0);
    idle(11);
    step(0, 0, 0, 0, 0, 0);
    idle(1);
    // one-shot P=4 H=4, restart on the done cycle
    step(1, 1, 1, 4, 4, 0);
    idle(4);
    step(1, 1, 1, 2, 1, 0);
    idle(3);
    // burst P=3 H=1 N=3, start during run ignored
    step(1, 1, 2, 3, 1, 3);
    idle(1);
    step(1, 1, 0, 7, 7, 0);
    idle(8);
    // config errors and start with enable low
    step(1, 1, 0, 0, 1, 0); idle(1);
    step(1, 1, 0, 5, 0, 0); idle(1);
    step(1, 1, 0, 5, 6, 0); idle(1);
    step(1, 1, 3, 5, 2, 1); idle(1);
    step(1, 1, 2, 5, 2, 0); idle(1);
    step(0, 1, 0, 5, 2, 0); idle(1);
    // randomized traffic
    for (int i = 0; i < 500; i++)
      step(($urandom % 16) != 0, ($urandom % 4) == 0, $urandom % 4,
           $urandom_range(0, 7), $urandom_range(0, 8), $urandom_range(0, 3));
    step(0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
